// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF pair sequencer.
package puf_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_COUNT   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // RO index for a pair: base challenge plus pair offset, wrapping mod 16.
  function automatic logic [SEL_W-1:0] pair_sel(input logic [SEL_W-1:0] base,
                                                input logic [SEL_W-1:0] offs);
    return base + offs;
  endfunction

endpackage

// File: rtl/edge_counter.sv
// Synchronises one asynchronous RO signal, detects its rising edges and
// counts them into a saturating counter while enabled.
module edge_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise_d;

  assign rise_d = sync_q[1] & ~prev_q;
  assign cnt_o  = cnt_q;

  // Two-flop synchroniser plus previous-value register for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sig_i};
      prev_q <= sync_q[1];
    end
  end

  // Edge count; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && rise_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ro_puf_pair_ctrl.sv
// RO PUF pair sequencer: walks RESP_BITS RO pairs from the challenge base
// indices, counts edges of both mux outputs per pair, and shifts in one
// comparison bit per pair (first pair ends up in bit 0).
//
// state   | meaning
// IDLE    | waiting for start; response/tie hold last result
// SETTLE  | selects just changed, counters held at zero
// COUNT   | both edge counters enabled for WINDOW cycles
// COMPARE | shift in (cnt_a > cnt_b), accumulate tie, advance pair
// DONE    | one-cycle done pulse, busy released
module ro_puf_pair_ctrl
  import puf_pkg::*;
#(
  parameter int RESP_BITS  = 8,
  parameter int WINDOW     = 64,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [SEL_W-1:0]     chal_a_i,
  input  logic [SEL_W-1:0]     chal_b_i,
  input  logic                 mux_a_out_i,
  input  logic                 mux_b_out_i,
  output logic [SEL_W-1:0]     sel_a_o,
  output logic [SEL_W-1:0]     sel_b_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [RESP_BITS-1:0] response_o,
  output logic                 tie_o
);

  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int KW      = $clog2(RESP_BITS) + 1;

  state_e               state_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [KW-1:0]        k_q;
  logic [SEL_W-1:0]     chal_a_q, chal_b_q;
  logic [SEL_W-1:0]     sel_a_q, sel_b_q;
  logic                 busy_q, done_q, tie_q;
  logic [RESP_BITS-1:0] resp_q;

  logic [CNT_W-1:0]     cnt_a, cnt_b;
  logic                 bit_d, eq_d;
  logic [RESP_BITS-1:0] resp_d;
  logic [SEL_W-1:0]     offs_d;

  edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sig_i (mux_a_out_i),
    .clr_i (state_q == ST_SETTLE),
    .en_i  (state_q == ST_COUNT),
    .cnt_o (cnt_a)
  );

  edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sig_i (mux_b_out_i),
    .clr_i (state_q == ST_SETTLE),
    .en_i  (state_q == ST_COUNT),
    .cnt_o (cnt_b)
  );

  assign bit_d  = (cnt_a > cnt_b);
  assign eq_d   = (cnt_a == cnt_b);
  // Right shift of {bit, resp} keeps the new bit at the MSB; also valid for RESP_BITS=1.
  assign resp_d = RESP_BITS'({bit_d, resp_q} >> 1);
  assign offs_d = SEL_W'(k_q) + 1'b1;

  // Sequencer: state, window/settle down-counter, pair index and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      k_q      <= '0;
      chal_a_q <= '0;
      chal_b_q <= '0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tie_q    <= 1'b0;
      resp_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            chal_a_q <= chal_a_i;
            chal_b_q <= chal_b_i;
            sel_a_q  <= chal_a_i;
            sel_b_q  <= chal_b_i;
            k_q      <= '0;
            resp_q   <= '0;
            tie_q    <= 1'b0;
            busy_q   <= 1'b1;
            tmr_q    <= TMR_W'(SETTLE_CYC - 1);
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == '0) begin
            tmr_q   <= TMR_W'(WINDOW - 1);
            state_q <= ST_COUNT;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_COUNT: begin
          if (tmr_q == '0) begin
            state_q <= ST_COMPARE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_COMPARE: begin
          resp_q <= resp_d;
          tie_q  <= tie_q | eq_d;
          if (k_q == KW'(RESP_BITS - 1)) begin
            state_q <= ST_DONE;
          end else begin
            k_q     <= k_q + 1'b1;
            sel_a_q <= pair_sel(chal_a_q, offs_d);
            sel_b_q <= pair_sel(chal_b_q, offs_d);
            tmr_q   <= TMR_W'(SETTLE_CYC - 1);
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_a_o    = sel_a_q;
  assign sel_b_o    = sel_b_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign response_o = resp_q;
  assign tie_o      = tie_q;

endmodule
